afu_ctrl_sequencer: RTL and testbench
=====================================

AFU_CTRL_SEQUENCER -- requirements
Module: afu_ctrl_sequencer

Interface
REQ-001 SHALL have parameter: POLL_DELAY, 64, idle cycles between a consumed control-word response and the next control-word read request (1..65535).
REQ-002 SHALL have parameter: CTRL_MDATA, 16'd3, mdata tag on control-word read requests.
REQ-003 SHALL have ports:
  clk  in  1  sole clock, all logic on posedge
  reset  in  1  synchronous, active-high
  enable  in  1  host-enabled; level
  ctrl_addr  in  42  cache-line address of control word; stable while enable=1
  rd_almfull  in  1  read request channel almost-full
  rd_req_valid  out  1  one-cycle control-word read request
  rd_req_addr  out  42  request address
  rd_req_mdata  out  16  request mdata
  ctrl_ack  in  1  decoded control response arrived (stale or fresh)
  ctrl_valid  in  1  response carries a new nonce; qualified only by ctrl_ack
  ctrl_code  in  3  control code: 0 NONE, 1 START_RUN
  ctrl_rd_addr  in  42  run read address (CL)
  ctrl_wr_addr  in  42  run write address (CL)
  ctrl_num_cls  in  32  run length in cache lines
  run_start  out  1  one-cycle launch of run engine
  run_rd_addr  out  42  latched run read address
  run_wr_addr  out  42  latched run write address
  run_num_cls  out  32  latched run length
  run_done  in  1  run engine completion pulse
  afu_state  out  3  current state: 0 IDLE, 1 CTRL, 2 RUN, 3 DONE
  runs_completed  out  32  count of DONE entries since reset

Function
REQ-004 SHALL implement states IDLE, CTRL, RUN, DONE; afu_state SHALL equal the registered state.
REQ-005 IDLE: enable=1 SHALL move to CTRL next cycle with poll timer=0 and no request pending.
REQ-006 CTRL: when pending=0, timer=0, rd_almfull=0 and enable=1, SHALL assert rd_req_valid for exactly one cycle with rd_req_addr=ctrl_addr, rd_req_mdata=CTRL_MDATA, and set pending=1.
REQ-007 At most one control request SHALL be outstanding; rd_req_valid SHALL be 0 while pending=1, and in every state other than CTRL.
REQ-008 rd_almfull=1 SHALL stall issue; the request SHALL go out in the first cycle rd_almfull=0 with other REQ-006 conditions true.
REQ-009 ctrl_ack while pending=0 SHALL be ignored (no state, timer or latch change).
REQ-010 ctrl_ack while pending=1 SHALL clear pending; if ctrl_valid=1 and ctrl_code=START_RUN, SHALL latch run_rd_addr/run_wr_addr/run_num_cls from inputs and move to RUN; otherwise (stale, NONE or unknown code) SHALL load timer=POLL_DELAY and stay in CTRL.
REQ-011 Timer SHALL decrement by 1 per cycle while nonzero in CTRL; no request until it reaches 0.
REQ-012 START_RUN with ctrl_num_cls=0 SHALL go straight to DONE with no run_start pulse.
REQ-013 run_start SHALL be 1 exactly in the first RUN cycle; run_* outputs SHALL hold from latch until next latch.
REQ-014 RUN: run_done SHALL move to DONE next cycle; run_done coincident with run_start SHALL be ignored; run_done outside RUN SHALL be ignored.
REQ-015 DONE lasts one cycle; runs_completed SHALL increment by 1, saturating at 32'hFFFF_FFFF; next state CTRL with timer=POLL_DELAY if enable=1, else IDLE.
REQ-016 enable=0 in CTRL with pending=0 SHALL go to IDLE next cycle; with pending=1 SHALL wait for ctrl_ack, discard its contents, then go IDLE.
REQ-017 enable=0 in RUN SHALL not abort the run; REQ-015 handles exit.

Reset
REQ-018 reset=1 SHALL force IDLE, pending=0, timer=0, runs_completed=0, rd_req_valid=0, run_start=0, rd_req_addr=0, rd_req_mdata=0, run_rd_addr=0, run_wr_addr=0, run_num_cls=0, next cycle, overriding all inputs in any state.
REQ-019 A ctrl_ack or run_done arriving after reset mid-operation SHALL be ignored per REQ-009/REQ-014.

Verification
REQ-020 enable=1, ctrl_addr=0x100 -> one rd_req_valid, addr 0x100, mdata 3, afu_state 1, no second request before ack.
REQ-021 ack with ctrl_valid=0 -> next request exactly POLL_DELAY+1 cycles after ack; with rd_almfull=1 held 10 extra cycles -> request delayed 10 cycles.
REQ-022 ack, valid, code 1, rd 0x40, wr 0x80, num 16 -> afu_state 2, single run_start, run_* = 0x40/0x80/16; run_done -> DONE one cycle, runs_completed=1, back to CTRL.
REQ-023 START_RUN with num_cls=0 -> no run_start, DONE, runs_completed increments.
REQ-024 enable dropped with request pending -> stays CTRL until ack, then IDLE, no run_start even if ack carries START_RUN.
REQ-025 reset asserted in RUN, then stray run_done -> afu_state 0, runs_completed 0, no transitions.

Source files
------------

// File: rtl/afu_ctrl_sequencer.sv
// rtl/afu_ctrl_sequencer.sv - polls a host control word and launches/sequences run-engine passes
module afu_ctrl_sequencer #(
  parameter int unsigned POLL_DELAY = 64,
  parameter logic [15:0] CTRL_MDATA = 16'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [41:0] ctrl_addr,
  input  logic        rd_almfull,
  output logic        rd_req_valid,
  output logic [41:0] rd_req_addr,
  output logic [15:0] rd_req_mdata,
  input  logic        ctrl_ack,
  input  logic        ctrl_valid,
  input  logic [2:0]  ctrl_code,
  input  logic [41:0] ctrl_rd_addr,
  input  logic [41:0] ctrl_wr_addr,
  input  logic [31:0] ctrl_num_cls,
  output logic        run_start,
  output logic [41:0] run_rd_addr,
  output logic [41:0] run_wr_addr,
  output logic [31:0] run_num_cls,
  input  logic        run_done,
  output logic [2:0]  afu_state,
  output logic [31:0] runs_completed
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CTRL = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3
  } state_t;

  localparam logic [15:0] DELAY          = 16'(POLL_DELAY);
  localparam logic [2:0]  CODE_START_RUN = 3'd1;

  state_t      state;
  logic        pending;
  logic [15:0] timer;

  assign afu_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      pending        <= 1'b0;
      timer          <= '0;
      runs_completed <= '0;
      rd_req_valid   <= 1'b0;
      rd_req_addr    <= '0;
      rd_req_mdata   <= '0;
      run_start      <= 1'b0;
      run_rd_addr    <= '0;
      run_wr_addr    <= '0;
      run_num_cls    <= '0;
    end else begin
      rd_req_valid <= 1'b0;
      run_start    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state   <= S_CTRL;
            timer   <= '0;
            pending <= 1'b0;
          end
        end
        S_CTRL: begin
          // An outstanding response must be drained even when the host disables us.
          if (pending && ctrl_ack) begin
            pending <= 1'b0;
            if (!enable) begin
              state <= S_IDLE;
            end else if (ctrl_valid && ctrl_code == CODE_START_RUN) begin
              run_rd_addr <= ctrl_rd_addr;
              run_wr_addr <= ctrl_wr_addr;
              run_num_cls <= ctrl_num_cls;
              if (ctrl_num_cls == '0) begin
                state <= S_DONE;
              end else begin
                state     <= S_RUN;
                run_start <= 1'b1;
              end
            end else begin
              timer <= DELAY;
            end
          end else if (!pending && !enable) begin
            state <= S_IDLE;
          end else if (!pending && timer == '0 && !rd_almfull) begin
            rd_req_valid <= 1'b1;
            rd_req_addr  <= ctrl_addr;
            rd_req_mdata <= CTRL_MDATA;
            pending      <= 1'b1;
          end else if (timer != '0) begin
            timer <= timer - 16'd1;
          end
        end
        S_RUN: begin
          // run_start is high only in the first RUN cycle, masking a same-cycle done.
          if (run_done && !run_start) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (runs_completed != 32'hFFFF_FFFF) begin
            runs_completed <= runs_completed + 32'd1;
          end
          if (enable) begin
            state <= S_CTRL;
            timer <= DELAY;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afu_ctrl_sequencer.sv
// tb/tb_afu_ctrl_sequencer.sv - randomized scenario bench for afu_ctrl_sequencer
module tb_afu_ctrl_sequencer;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset, enable, rd_almfull, ctrl_ack, ctrl_valid, run_done;
  logic [41:0] ctrl_addr, ctrl_rd_addr, ctrl_wr_addr;
  logic [2:0]  ctrl_code;
  logic [31:0] ctrl_num_cls;
  logic        rd_req_valid, run_start;
  logic [41:0] rd_req_addr, run_rd_addr, run_wr_addr;
  logic [15:0] rd_req_mdata;
  logic [31:0] run_num_cls, runs_completed;
  logic [2:0]  afu_state;

  afu_ctrl_sequencer #(.POLL_DELAY(D), .CTRL_MDATA(16'd3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ctrl_addr(ctrl_addr),
    .rd_almfull(rd_almfull), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_mdata(rd_req_mdata), .ctrl_ack(ctrl_ack), .ctrl_valid(ctrl_valid),
    .ctrl_code(ctrl_code), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_wr_addr(ctrl_wr_addr),
    .ctrl_num_cls(ctrl_num_cls), .run_start(run_start), .run_rd_addr(run_rd_addr),
    .run_wr_addr(run_wr_addr), .run_num_cls(run_num_cls), .run_done(run_done),
    .afu_state(afu_state), .runs_completed(runs_completed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, errors = 0;
  int req_cnt = 0, start_cnt = 0, last_req_cyc = 0;
  logic [41:0] last_req_addr;
  logic [15:0] last_req_mdata;
  logic [31:0] exp_runs = 0;

  // Event log: every request/launch pulse stamped with the edge that produced it.
  always begin
    @(posedge clk);
    #2;
    if (rd_req_valid) begin
      req_cnt++;
      last_req_cyc   = cyc;
      last_req_addr  = rd_req_addr;
      last_req_mdata = rd_req_mdata;
    end
    if (run_start) start_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_ack(input logic v, input logic [2:0] code, input logic [41:0] rd,
                        input logic [41:0] wr, input logic [31:0] n, output int at);
    ctrl_ack = 1'b1; ctrl_valid = v; ctrl_code = code;
    ctrl_rd_addr = rd; ctrl_wr_addr = wr; ctrl_num_cls = n;
    step();
    at = cyc;
    ctrl_ack = 1'b0; ctrl_valid = 1'b0; ctrl_code = 3'd0;
  endtask

  task automatic wait_req(input int budget, output int at, output bit ok);
    int base = req_cnt;
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (req_cnt != base) begin ok = 1'b1; at = last_req_cyc; break; end
    end
  endtask

  function automatic logic [41:0] rand42();
    return {10'($urandom()), $urandom()};
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; ctrl_ack = 1'b1; ctrl_valid = 1'b1; ctrl_code = 3'd1;
    run_done = 1'b1; rd_almfull = 1'b0;
    step(); step();
    vectors++; if (afu_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", afu_state); end
    vectors++; if (rd_req_valid !== 1'b0 || run_start !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", rd_req_valid, run_start); end
    vectors++; if (rd_req_addr !== '0 || rd_req_mdata !== '0) begin errors++; $display("FAIL reset_req got %h/%h exp 0/0", rd_req_addr, rd_req_mdata); end
    vectors++; if (run_rd_addr !== '0 || run_wr_addr !== '0 || run_num_cls !== '0) begin errors++; $display("FAIL reset_run got %h/%h/%h exp 0", run_rd_addr, run_wr_addr, run_num_cls); end
    vectors++; if (runs_completed !== 32'd0) begin errors++; $display("FAIL reset_runs got %0d exp 0", runs_completed); end
    reset = 1'b0; enable = 1'b0; ctrl_ack = 1'b0; ctrl_valid = 1'b0; ctrl_code = 3'd0; run_done = 1'b0;
    step(); step();
    vectors++; if (afu_state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", afu_state); end
  endtask

  task automatic test_first_request();
    int e, at, base; bit ok;
    ctrl_addr = 42'h100; enable = 1'b1;
    step(); e = cyc;
    vectors++; if (afu_state !== 3'd1) begin errors++; $display("FAIL first_state got %0d exp 1", afu_state); end
    base = req_cnt;
    wait_req(6, at, ok);
    vectors++; if (!ok || at != e + 1) begin errors++; $display("FAIL first_req_time got %0d exp %0d", at, e + 1); end
    vectors++; if (last_req_addr !== 42'h100 || last_req_mdata !== 16'd3) begin errors++; $display("FAIL first_req_fields got %h/%0d exp 100/3", last_req_addr, last_req_mdata); end
    repeat (20) step();
    vectors++; if (req_cnt != base + 1) begin errors++; $display("FAIL single_outstanding got %0d exp %0d", req_cnt - base, 1); end
  endtask

  task automatic test_poll_delay();
    int a, at, stall; bit ok; logic v; logic [2:0] code;
    for (int i = 0; i < 6; i++) begin
      stall = (i == 0) ? 0 : (i == 1) ? 10 : int'($urandom_range(0, 12));
      case ($urandom_range(0, 2))
        0: begin v = 1'b0; code = 3'($urandom()); end
        1: begin v = 1'b1; code = 3'd0; end
        default: begin v = 1'b1; code = 3'($urandom_range(2, 7)); end
      endcase
      rd_almfull = (stall > 0);
      do_ack(v, code, rand42(), rand42(), 32'd7, a);
      vectors++; if (afu_state !== 3'd1 || run_start !== 1'b0) begin errors++; $display("FAIL stale_state got %0d/%b exp 1/0", afu_state, run_start); end
      if (stall > 0) begin
        repeat (D + stall) step();
        rd_almfull = 1'b0;
      end
      wait_req(D + stall + 6, at, ok);
      vectors++; if (!ok || at != a + D + stall + 1) begin errors++; $display("FAIL poll_delay stall=%0d got %0d exp %0d", stall, at - a, D + stall + 1); end
      vectors++; if (last_req_addr !== ctrl_addr) begin errors++; $display("FAIL poll_addr got %h exp %h", last_req_addr, ctrl_addr); end
    end
  endtask

  task automatic test_run();
    int a, r, at, sbase; bit ok; logic [41:0] rd, wr; logic [31:0] n;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin rd = 42'h40; wr = 42'h80; n = 32'd16; end
      else begin rd = rand42(); wr = rand42(); n = $urandom_range(1, 1000); end
      sbase = start_cnt;
      do_ack(1'b1, 3'd1, rd, wr, n, a);
      vectors++; if (afu_state !== 3'd2 || run_start !== 1'b1) begin errors++; $display("FAIL run_entry got %0d/%b exp 2/1", afu_state, run_start); end
      vectors++; if (run_rd_addr !== rd || run_wr_addr !== wr || run_num_cls !== n) begin errors++; $display("FAIL run_latch got %h/%h/%0d exp %h/%h/%0d", run_rd_addr, run_wr_addr, run_num_cls, rd, wr, n); end
      run_done = i[0];
      step();
      run_done = 1'b0;
      vectors++; if (afu_state !== 3'd2 || run_start !== 1'b0) begin errors++; $display("FAIL run_hold got %0d/%b exp 2/0", afu_state, run_start); end
      repeat ($urandom_range(0, 5)) step();
      run_done = 1'b1; step(); r = cyc; run_done = 1'b0;
      vectors++; if (afu_state !== 3'd3) begin errors++; $display("FAIL done_state got %0d exp 3", afu_state); end
      step();
      exp_runs++;
      vectors++; if (afu_state !== 3'd1 || runs_completed !== exp_runs) begin errors++; $display("FAIL after_done got %0d/%0d exp 1/%0d", afu_state, runs_completed, exp_runs); end
      vectors++; if (start_cnt != sbase + 1) begin errors++; $display("FAIL run_start_count got %0d exp 1", start_cnt - sbase); end
      wait_req(D + 6, at, ok);
      vectors++; if (!ok || at != r + D + 2) begin errors++; $display("FAIL repoll got %0d exp %0d", at - r, D + 2); end
    end
  endtask

  task automatic test_zero_len();
    int a, at, sbase; bit ok;
    sbase = start_cnt;
    do_ack(1'b1, 3'd1, rand42(), rand42(), 32'd0, a);
    vectors++; if (afu_state !== 3'd3 || run_start !== 1'b0) begin errors++; $display("FAIL zero_len got %0d/%b exp 3/0", afu_state, run_start); end
    step(); exp_runs++;
    vectors++; if (afu_state !== 3'd1 || runs_completed !== exp_runs || start_cnt != sbase) begin errors++; $display("FAIL zero_len_after got %0d/%0d/%0d exp 1/%0d/0", afu_state, runs_completed, start_cnt - sbase, exp_runs); end
    wait_req(D + 6, at, ok);
    vectors++; if (!ok || at != a + D + 2) begin errors++; $display("FAIL zero_len_repoll got %0d exp %0d", at - a, D + 2); end
  endtask

  task automatic test_disable_pending();
    int a, e, at, sbase, rbase; bit ok;
    sbase = start_cnt; rbase = req_cnt;
    enable = 1'b0;
    repeat ($urandom_range(1, 8)) step();
    vectors++; if (afu_state !== 3'd1) begin errors++; $display("FAIL disable_wait got %0d exp 1", afu_state); end
    do_ack(1'b1, 3'd1, rand42(), rand42(), 32'd5, a);
    vectors++; if (afu_state !== 3'd0) begin errors++; $display("FAIL disable_idle got %0d exp 0", afu_state); end
    repeat (5) step();
    vectors++; if (start_cnt != sbase || req_cnt != rbase || runs_completed !== exp_runs) begin errors++; $display("FAIL disable_quiet got %0d/%0d/%0d exp 0/0/%0d", start_cnt - sbase, req_cnt - rbase, runs_completed, exp_runs); end
    enable = 1'b1; step(); e = cyc;
    wait_req(6, at, ok);
    vectors++; if (!ok || at != e + 1) begin errors++; $display("FAIL reenable_req got %0d exp %0d", at, e + 1); end
  endtask

  task automatic test_disable_countdown();
    int a, e, at, rbase; bit ok;
    do_ack(1'b0, 3'd0, '0, '0, '0, a);
    step(); step();
    enable = 1'b0; step();
    vectors++; if (afu_state !== 3'd0) begin errors++; $display("FAIL countdown_idle got %0d exp 0", afu_state); end
    rbase = req_cnt;
    repeat (D + 4) step();
    vectors++; if (req_cnt != rbase) begin errors++; $display("FAIL idle_no_req got %0d exp 0", req_cnt - rbase); end
    enable = 1'b1; step(); e = cyc;
    wait_req(6, at, ok);
    vectors++; if (!ok || at != e + 1) begin errors++; $display("FAIL countdown_reenable got %0d exp %0d", at, e + 1); end
  endtask

  task automatic test_run_disable();
    int a;
    do_ack(1'b1, 3'd1, rand42(), rand42(), 32'd4, a);
    enable = 1'b0;
    repeat (3) step();
    vectors++; if (afu_state !== 3'd2) begin errors++; $display("FAIL run_no_abort got %0d exp 2", afu_state); end
    run_done = 1'b1; step(); run_done = 1'b0;
    vectors++; if (afu_state !== 3'd3) begin errors++; $display("FAIL run_dis_done got %0d exp 3", afu_state); end
    step(); exp_runs++;
    vectors++; if (afu_state !== 3'd0 || runs_completed !== exp_runs) begin errors++; $display("FAIL run_dis_exit got %0d/%0d exp 0/%0d", afu_state, runs_completed, exp_runs); end
  endtask

  task automatic test_reset_mid_run();
    int a, at, sbase; bit ok;
    enable = 1'b1; step();
    wait_req(6, at, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL pre_reset_req got none exp one"); end
    do_ack(1'b1, 3'd1, rand42(), rand42(), 32'd9, a);
    vectors++; if (afu_state !== 3'd2) begin errors++; $display("FAIL pre_reset_run got %0d exp 2", afu_state); end
    reset = 1'b1; enable = 1'b0; step(); reset = 1'b0;
    exp_runs = 0; sbase = start_cnt;
    vectors++; if (afu_state !== 3'd0 || runs_completed !== exp_runs || run_rd_addr !== '0 || run_num_cls !== '0) begin errors++; $display("FAIL mid_reset got %0d/%0d/%h/%0d exp 0/0/0/0", afu_state, runs_completed, run_rd_addr, run_num_cls); end
    run_done = 1'b1; step(); run_done = 1'b0;
    do_ack(1'b1, 3'd1, rand42(), rand42(), 32'd3, a);
    repeat (3) step();
    vectors++; if (afu_state !== 3'd0 || runs_completed !== exp_runs || start_cnt != sbase) begin errors++; $display("FAIL stray_events got %0d/%0d/%0d exp 0/0/0", afu_state, runs_completed, start_cnt - sbase); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rd_almfull = 1'b0; ctrl_ack = 1'b0; ctrl_valid = 1'b0;
    ctrl_code = 3'd0; run_done = 1'b0; ctrl_addr = '0; ctrl_rd_addr = '0; ctrl_wr_addr = '0;
    ctrl_num_cls = '0;
    step();
    test_reset();
    test_first_request();
    test_poll_delay();
    test_run();
    test_zero_len();
    test_disable_pending();
    test_disable_countdown();
    test_run_disable();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
